// File: rtl/tsn_gate_ctrl_if.sv
// Configuration, queue-status and gate-output signals of the TSN gate-control stage.
interface tsn_gate_ctrl_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DUR_W  = 16
);
   logic              in_gate_cfg_wr;
   logic [ADDR_W-1:0] in_gate_cfg_addr;
   logic [7:0]        in_gate_cfg_mask;
   logic [DUR_W-1:0]  in_gate_cfg_dur;
   logic [ADDR_W:0]   in_gate_cfg_len;
   logic              in_gate_test_start;
   logic [7:0]        in_gate_queue_empty;
   logic [7:0]        out_gate_valid;
   logic [ADDR_W-1:0] out_gate_slot;
   logic              out_gate_cycle_start;

   modport master (
      output in_gate_cfg_wr, in_gate_cfg_addr, in_gate_cfg_mask, in_gate_cfg_dur,
             in_gate_cfg_len, in_gate_test_start, in_gate_queue_empty,
      input  out_gate_valid, out_gate_slot, out_gate_cycle_start
   );

   modport slave (
      input  in_gate_cfg_wr, in_gate_cfg_addr, in_gate_cfg_mask, in_gate_cfg_dur,
             in_gate_cfg_len, in_gate_test_start, in_gate_queue_empty,
      output out_gate_valid, out_gate_slot, out_gate_cycle_start
   );
endinterface

// File: rtl/tsn_gate_ctrl.sv
// Cyclic gate control list runner gating the 8 queue-eligible flags of the scheduler.
// Define GATE_GUARD_BAND_EN to withdraw queues whose gate closes within GUARD_CYCLES.
module tsn_gate_ctrl #(
   parameter int unsigned GCL_DEPTH    = 16,
   parameter int unsigned ADDR_W       = 4,
   parameter int unsigned DUR_W        = 16,
   parameter int unsigned GUARD_CYCLES = 8
) (
   input logic           clk,
   input logic           rst_n,
   tsn_gate_ctrl_if.slave gate
);
   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e            state_q;
   logic [7:0]        gcl_mask_q [GCL_DEPTH];
   logic [DUR_W-1:0]  gcl_dur_q  [GCL_DEPTH];
   logic [ADDR_W-1:0] slot_q;
   logic [DUR_W-1:0]  cnt_q;
   logic [ADDR_W:0]   len_q;
   logic [7:0]        valid_q;
   logic              cycle_start_q;

   logic              wr_ok;
   logic              cfg_len_ok;
   logic [ADDR_W:0]   slot_inc;
   logic              wrap;
   logic [ADDR_W-1:0] slot_nxt;
   logic [7:0]        guard_mask;

   function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
      return (d == '0) ? DUR_W'(1) : d;
   endfunction

   assign wr_ok      = gate.in_gate_cfg_wr && (32'(gate.in_gate_cfg_addr) < GCL_DEPTH);
   assign cfg_len_ok = (gate.in_gate_cfg_len != '0) && (32'(gate.in_gate_cfg_len) <= GCL_DEPTH);
   assign slot_inc   = {1'b0, slot_q} + (ADDR_W+1)'(1);
   assign wrap       = (slot_inc == len_q);
   assign slot_nxt   = wrap ? '0 : slot_inc[ADDR_W-1:0];

`ifdef GATE_GUARD_BAND_EN
   // Near the boundary only queues that stay open in the next entry remain eligible.
   assign guard_mask = (32'(cnt_q) <= GUARD_CYCLES) ? gcl_mask_q[slot_nxt] : 8'hFF;
`else
   logic unused_guard;
   assign unused_guard = (GUARD_CYCLES != 0);
   assign guard_mask   = 8'hFF;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(GCL_DEPTH); i++) begin
            gcl_mask_q[i] <= '0;
            gcl_dur_q[i]  <= '0;
         end
      end else if (wr_ok) begin
         gcl_mask_q[gate.in_gate_cfg_addr] <= gate.in_gate_cfg_mask;
         gcl_dur_q[gate.in_gate_cfg_addr]  <= gate.in_gate_cfg_dur;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         slot_q        <= '0;
         cnt_q         <= '0;
         len_q         <= '0;
         valid_q       <= '0;
         cycle_start_q <= 1'b0;
      end else begin
         cycle_start_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               valid_q <= '0;
               slot_q  <= '0;
               if (gate.in_gate_test_start && cfg_len_ok) begin
                  state_q       <= StRun;
                  cnt_q         <= eff_dur(gcl_dur_q[0]);
                  len_q         <= gate.in_gate_cfg_len;
                  cycle_start_q <= 1'b1;
               end
            end
            StRun: begin
               if (!gate.in_gate_test_start) begin
                  state_q <= StIdle;
                  valid_q <= '0;
                  slot_q  <= '0;
               end else begin
                  valid_q <= gcl_mask_q[slot_q] & ~gate.in_gate_queue_empty & guard_mask;
                  if (cnt_q > DUR_W'(1)) begin
                     cnt_q <= cnt_q - DUR_W'(1);
                  end else if (wrap) begin
                     // Length changes take effect only at the cycle boundary.
                     len_q <= gate.in_gate_cfg_len;
                     slot_q <= '0;
                     if (cfg_len_ok) begin
                        cnt_q         <= eff_dur(gcl_dur_q[0]);
                        cycle_start_q <= 1'b1;
                     end else begin
                        state_q <= StIdle;
                        valid_q <= '0;
                     end
                  end else begin
                     slot_q <= slot_nxt;
                     cnt_q  <= eff_dur(gcl_dur_q[slot_nxt]);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign gate.out_gate_valid       = valid_q;
   assign gate.out_gate_slot        = slot_q;
   assign gate.out_gate_cycle_start = cycle_start_q;
endmodule

// File: tb/tb_tsn_gate_ctrl.sv
// Directed bench for tsn_gate_ctrl: per-cycle vector table plus multi-cycle corner sequences.
module tb_tsn_gate_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   tsn_gate_ctrl_if #(.ADDR_W(4), .DUR_W(16)) gif ();

   tsn_gate_ctrl #(
      .GCL_DEPTH   (16),
      .ADDR_W      (4),
      .DUR_W       (16),
      .GUARD_CYCLES(2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .gate (gif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       start;
      logic [7:0] empty;
      logic [7:0] v;
      logic [3:0] s;
      logic       c;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic st, input logic [7:0] em, input logic [7:0] v,
                      input logic [3:0] s, input logic c);
      vq.push_back('{start: st, empty: em, v: v, s: s, c: c});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] v, input logic [3:0] s,
                          input logic c);
      chk({tag, " valid"}, 32'(gif.out_gate_valid), 32'(v));
      chk({tag, " slot"}, 32'(gif.out_gate_slot), 32'(s));
      chk({tag, " cycle_start"}, 32'(gif.out_gate_cycle_start), 32'(c));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [7:0] m, input logic [15:0] d);
      gif.in_gate_cfg_wr   = 1'b1;
      gif.in_gate_cfg_addr = a;
      gif.in_gate_cfg_mask = m;
      gif.in_gate_cfg_dur  = d;
      step();
      gif.in_gate_cfg_wr = 1'b0;
   endtask

   initial begin
      logic [7:0] ev;
      logic [3:0] es;
      logic       ec;

      gif.in_gate_cfg_wr      = 1'b0;
      gif.in_gate_cfg_addr    = '0;
      gif.in_gate_cfg_mask    = '0;
      gif.in_gate_cfg_dur     = '0;
      gif.in_gate_cfg_len     = '0;
      gif.in_gate_test_start  = 1'b0;
      gif.in_gate_queue_empty = '0;
      @(negedge clk);
      @(negedge clk);
      chk_out("reset", 8'h00, 4'd0, 1'b0);
      rst_n = 1'b1;

      // Two-entry schedule, then empty-flag changes, then stop/restart in slot 1.
      cfg_write(4'd0, 8'h01, 16'd4);
      cfg_write(4'd1, 8'h80, 16'd2);
      gif.in_gate_cfg_len = 5'd2;
      add(0, 8'h00, 8'h00, 0, 0);
      add(1, 8'h00, 8'h00, 0, 1);
      add(1, 8'h00, 8'h01, 0, 0); add(1, 8'h00, 8'h01, 0, 0); add(1, 8'h00, 8'h01, 0, 0);
      add(1, 8'h00, 8'h01, 1, 0); add(1, 8'h00, 8'h80, 1, 0); add(1, 8'h00, 8'h80, 0, 1);
      add(1, 8'h00, 8'h01, 0, 0); add(1, 8'h00, 8'h01, 0, 0); add(1, 8'h00, 8'h01, 0, 0);
      add(1, 8'h00, 8'h01, 1, 0); add(1, 8'h00, 8'h80, 1, 0); add(1, 8'h00, 8'h80, 0, 1);
      add(1, 8'hFE, 8'h01, 0, 0); add(1, 8'hFE, 8'h01, 0, 0); add(1, 8'hFE, 8'h01, 0, 0);
      add(1, 8'hFE, 8'h01, 1, 0); add(1, 8'hFE, 8'h00, 1, 0); add(1, 8'hFE, 8'h00, 0, 1);
      add(1, 8'hFE, 8'h01, 0, 0); add(1, 8'hFE, 8'h01, 0, 0); add(1, 8'hFE, 8'h01, 0, 0);
      add(1, 8'hFE, 8'h01, 1, 0); add(1, 8'h7E, 8'h80, 1, 0); add(1, 8'h7E, 8'h80, 0, 1);
      add(1, 8'h00, 8'h01, 0, 0); add(1, 8'h00, 8'h01, 0, 0); add(1, 8'h00, 8'h01, 0, 0);
      add(1, 8'h00, 8'h01, 1, 0);
      add(0, 8'h00, 8'h00, 0, 0);
      add(1, 8'h00, 8'h00, 0, 1);
      add(1, 8'h00, 8'h01, 0, 0); add(1, 8'h00, 8'h01, 0, 0); add(1, 8'h00, 8'h01, 0, 0);
      add(1, 8'h00, 8'h01, 1, 0); add(1, 8'h00, 8'h80, 1, 0);
      foreach (vq[i]) begin
         gif.in_gate_test_start  = vq[i].start;
         gif.in_gate_queue_empty = vq[i].empty;
         step();
         chk_out($sformatf("vec%0d", i), vq[i].v, vq[i].s, vq[i].c);
      end
      gif.in_gate_test_start = 1'b0;
      step();

      // Zero duration with one entry: wraps every cycle.
      cfg_write(4'd0, 8'hFF, 16'd0);
      gif.in_gate_cfg_len     = 5'd1;
      gif.in_gate_queue_empty = 8'h0F;
      gif.in_gate_test_start  = 1'b1;
      step();
      chk_out("dur0 start", 8'h00, 4'd0, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk_out($sformatf("dur0 k%0d", k), 8'hF0, 4'd0, 1'b1);
      end
      gif.in_gate_test_start = 1'b0;
      step();

      // Length 2 -> 1 in slot 0, then 0 later: idles at the following wrap.
      cfg_write(4'd0, 8'h01, 16'd4);
      cfg_write(4'd1, 8'h80, 16'd2);
      gif.in_gate_cfg_len     = 5'd2;
      gif.in_gate_queue_empty = 8'h00;
      gif.in_gate_test_start  = 1'b1;
      step();
      chk("len start cycle_start", 32'(gif.out_gate_cycle_start), 32'd1);
      for (int k = 1; k <= 15; k++) begin
         if (k == 2) gif.in_gate_cfg_len = 5'd1;
         if (k == 12) gif.in_gate_cfg_len = 5'd0;
         step();
         es = (k == 4 || k == 5) ? 4'd1 : 4'd0;
         ec = (k == 6 || k == 10);
         ev = (k <= 4) ? 8'h01 : (k <= 6) ? 8'h80 : (k <= 13) ? 8'h01 : 8'h00;
         chk_out($sformatf("len k%0d", k), ev, es, ec);
      end
      gif.in_gate_test_start = 1'b0;
      gif.in_gate_cfg_len    = 5'd2;
      step();

      // Write to next entry on the advance edge, then stop on a wrap edge.
      cfg_write(4'd0, 8'h01, 16'd2);
      cfg_write(4'd1, 8'h80, 16'd3);
      gif.in_gate_test_start = 1'b1;
      step();
      for (int k = 1; k <= 8; k++) begin
         if (k == 2) begin
            gif.in_gate_cfg_wr   = 1'b1;
            gif.in_gate_cfg_addr = 4'd1;
            gif.in_gate_cfg_mask = 8'h80;
            gif.in_gate_cfg_dur  = 16'd1;
         end
         if (k == 3) gif.in_gate_cfg_wr = 1'b0;
         if (k == 8) gif.in_gate_test_start = 1'b0;
         step();
         es = (k >= 2 && k <= 4) || k == 7 ? 4'd1 : 4'd0;
         ec = (k == 5);
         ev = (k <= 2 || k == 6 || k == 7) ? 8'h01 : (k <= 5) ? 8'h80 : 8'h00;
         chk_out($sformatf("simul k%0d", k), ev, es, ec);
      end

      // Guard band around the slot 0 -> slot 1 boundary.
      cfg_write(4'd0, 8'h03, 16'd10);
      cfg_write(4'd1, 8'h02, 16'd10);
      gif.in_gate_test_start = 1'b1;
      step();
      for (int k = 1; k <= 12; k++) begin
         step();
`ifdef GATE_GUARD_BAND_EN
         ev = (k <= 8) ? 8'h03 : 8'h02;
`else
         ev = (k <= 10) ? 8'h03 : 8'h02;
`endif
         chk($sformatf("guard k%0d valid", k), 32'(gif.out_gate_valid), 32'(ev));
      end
      chk("guard slot", 32'(gif.out_gate_slot), 32'd1);

      // Asynchronous reset mid-run clears outputs and GCL contents.
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("async reset", 8'h00, 4'd0, 1'b0);
      gif.in_gate_test_start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      gif.in_gate_cfg_len    = 5'd1;
      gif.in_gate_test_start = 1'b1;
      step();
      chk_out("post reset start", 8'h00, 4'd0, 1'b1);
      step();
      chk_out("post reset cleared gcl", 8'h00, 4'd0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
